// File: rtl/fp_operand_unpack.sv
// Purpose : binary32 add/sub input stage; unpacks both operands, restores the
//           hidden bit, orders them so |A| >= |B| and computes the exponent gap.
// Latency : 2 cycles (S1 operand register, S2 unpacked/ordered bundle).
// Backpressure: per-stage stall enables; o_ready is combinational from i_ready,
//           so a full pipeline accepts a new pair in the same cycle the output drains.
// Ports   : i_valid/o_ready/i_add_sub/i_op_a/i_op_b upstream handshake + operands;
//           o_valid/i_ready downstream handshake; o_add_sub, o_swap, o_sign_*,
//           o_exp_* (raw field), o_man_* ({hidden, frac}), o_exp_diff.
// Option  : `define FP_UNPACK_DENORM_FLUSH_EN forces subnormal fractions to zero
//           before ordering (sign and raw exponent are kept).
module fp_operand_unpack (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_add_sub,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_add_sub,
  output logic        o_swap,
  output logic        o_sign_a,
  output logic        o_sign_b,
  output logic [7:0]  o_exp_a,
  output logic [7:0]  o_exp_b,
  output logic [23:0] o_man_a,
  output logic [23:0] o_man_b,
  output logic [7:0]  o_exp_diff
);

  // Stage 1: raw operand capture
  logic        s1_valid;
  logic        s1_add_sub;
  logic [31:0] s1_op_a;
  logic [31:0] s1_op_b;

  logic s2_en;
  logic s1_en;

  assign s2_en   = ~o_valid | i_ready;
  assign s1_en   = ~s1_valid | s2_en;
  assign o_ready = s1_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_add_sub <= 1'b0;
      s1_op_a    <= 32'd0;
      s1_op_b    <= 32'd0;
    end else if (s1_en) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_add_sub <= i_add_sub;
        s1_op_a    <= i_op_a;
        s1_op_b    <= i_op_b;
      end
    end
  end

  // Field extraction from S1
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [23:0] man_a, man_b;
  logic [7:0]  eff_a, eff_b;
  logic        swap;

  assign exp_a = s1_op_a[30:23];
  assign exp_b = s1_op_b[30:23];

`ifdef FP_UNPACK_DENORM_FLUSH_EN
  assign frac_a = (exp_a == 8'd0) ? 23'd0 : s1_op_a[22:0];
  assign frac_b = (exp_b == 8'd0) ? 23'd0 : s1_op_b[22:0];
`else
  assign frac_a = s1_op_a[22:0];
  assign frac_b = s1_op_b[22:0];
`endif

  assign man_a = {(exp_a != 8'd0), frac_a};
  assign man_b = {(exp_b != 8'd0), frac_b};

  // Subnormals share the scale of exponent 1 for alignment purposes
  assign eff_a = (exp_a == 8'd0) ? 8'd1 : exp_a;
  assign eff_b = (exp_b == 8'd0) ? 8'd1 : exp_b;

  // Magnitude order: {exp, frac} as an unsigned integer; ties keep original order
  assign swap = ({exp_b, frac_b} > {exp_a, frac_a});

  // Stage 2: ordered bundle, driven straight onto the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_add_sub  <= 1'b0;
      o_swap     <= 1'b0;
      o_sign_a   <= 1'b0;
      o_sign_b   <= 1'b0;
      o_exp_a    <= 8'd0;
      o_exp_b    <= 8'd0;
      o_man_a    <= 24'd0;
      o_man_b    <= 24'd0;
      o_exp_diff <= 8'd0;
    end else if (s2_en) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_add_sub  <= s1_add_sub;
        o_swap     <= swap;
        o_sign_a   <= swap ? s1_op_b[31] : s1_op_a[31];
        o_sign_b   <= swap ? s1_op_a[31] : s1_op_b[31];
        o_exp_a    <= swap ? exp_b : exp_a;
        o_exp_b    <= swap ? exp_a : exp_b;
        o_man_a    <= swap ? man_b : man_a;
        o_man_b    <= swap ? man_a : man_b;
        // Slot A has the larger magnitude, so this never goes negative
        o_exp_diff <= swap ? (eff_b - eff_a) : (eff_a - eff_b);
      end
    end
  end

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Scoreboard bench for fp_operand_unpack: directed cases, backpressure,
// mid-stream reset and randomized traffic against a reference model.
module tb_fp_operand_unpack;

  typedef struct packed {
    logic        add_sub;
    logic        swap;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] man_a;
    logic [23:0] man_b;
    logic [7:0]  exp_diff;
  } bundle_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_add_sub = 1'b0;
  logic [31:0] i_op_a = 32'd0;
  logic [31:0] i_op_b = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_add_sub, o_swap, o_sign_a, o_sign_b;
  logic [7:0]  o_exp_a, o_exp_b, o_exp_diff;
  logic [23:0] o_man_a, o_man_b;

  fp_operand_unpack dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_sub(i_add_sub), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .o_valid(o_valid), .i_ready(i_ready), .o_add_sub(o_add_sub),
    .o_swap(o_swap), .o_sign_a(o_sign_a), .o_sign_b(o_sign_b),
    .o_exp_a(o_exp_a), .o_exp_b(o_exp_b), .o_man_a(o_man_a),
    .o_man_b(o_man_b), .o_exp_diff(o_exp_diff)
  );

  always #5 i_clk = ~i_clk;

  int      checks = 0;
  int      errors = 0;
  bundle_t exp_q[$];
  int      cyc = 0;
  int      rdy_mode = 0;   // 0 always ready, 1 random, 2 scheduled stall, 3 never
  int      bp_base = 0;
  bit      bp_on = 1'b0;

  function automatic bundle_t mk(input logic as, input logic sw, input logic sa,
                                 input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb,
                                 input logic [7:0] d);
    bundle_t r;
    r.add_sub = as; r.swap = sw; r.sign_a = sa; r.sign_b = sb;
    r.exp_a = ea; r.exp_b = eb; r.man_a = ma; r.man_b = mb; r.exp_diff = d;
    return r;
  endfunction

  // Reference: treat each operand as a number (sign, exponent, significand)
  function automatic bundle_t model(input logic as, input logic [31:0] a, input logic [31:0] b);
    int unsigned e[2], f[2], sg[2], eff[2], sig[2];
    longint unsigned mag[2];
    int hi, lo;
    bundle_t r;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] w;
      w = (k == 0) ? a : b;
      sg[k] = w[31];
      e[k]  = w[30:23];
      f[k]  = w[22:0];
`ifdef FP_UNPACK_DENORM_FLUSH_EN
      if (e[k] == 0) f[k] = 0;
`endif
      mag[k] = longint'(e[k]) * 64'd8388608 + longint'(f[k]);
      sig[k] = (e[k] == 0) ? f[k] : f[k] + 8388608;
      eff[k] = (e[k] == 0) ? 1 : e[k];
    end
    hi = (mag[1] > mag[0]) ? 1 : 0;
    lo = 1 - hi;
    r.add_sub  = as;
    r.swap     = (hi == 1);
    r.sign_a   = sg[hi][0];
    r.sign_b   = sg[lo][0];
    r.exp_a    = e[hi][7:0];
    r.exp_b    = e[lo][7:0];
    r.man_a    = sig[hi][23:0];
    r.man_b    = sig[lo][23:0];
    r.exp_diff = 8'(eff[hi] - eff[lo]);
    return r;
  endfunction

  function automatic logic pick_ready();
    int rel;
    rel = cyc - bp_base;
    case (rdy_mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      2:       return !(rel >= 3 && rel <= 6);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bundle_t outs();
    return mk(o_add_sub, o_swap, o_sign_a, o_sign_b, o_exp_a, o_exp_b,
              o_man_a, o_man_b, o_exp_diff);
  endfunction

  task automatic drive_cycle(input logic v, input logic as, input logic [31:0] a,
                             input logic [31:0] b, output logic acc);
    int rel;
    @(negedge i_clk);
    cyc++;
    i_ready   = pick_ready();
    i_valid   = v;
    i_add_sub = as;
    i_op_a    = a;
    i_op_b    = b;
    #1;
    acc = v && o_ready;
    rel = cyc - bp_base;
    if (bp_on && rel >= 3 && rel <= 6) begin
      checks++;
      if (o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low rel=%0d got o_ready=%b want 0", rel, o_ready);
      end
    end
    if (bp_on && rel == 7) begin
      checks++;
      if (o_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_rise got o_ready=%b want 1", o_ready);
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0, 32'd0, 32'd0, acc);
  endtask

  task automatic send(input logic as, input logic [31:0] a, input logic [31:0] b,
                      input bundle_t e);
    logic acc;
    int   guard;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 200) begin
      drive_cycle(1'b1, as, a, b, acc);
      guard++;
    end
    if (acc) exp_q.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no accept want o_ready within 200 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || outs() !== '0) begin
      errors++;
      $display("FAIL %s got valid=%b ready=%b data=%h want valid=0 ready=1 data=0",
               tag, o_valid, o_ready, outs());
    end
  endtask

  // Monitor: pops on every output transfer; also checks stability while stalled
  bit      prev_stall = 1'b0;
  bundle_t prev_out;
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      if (!i_rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (o_valid !== 1'b1 || outs() !== prev_out) begin
            errors++;
            $display("FAIL stall_hold got valid=%b data=%h want valid=1 data=%h",
                     o_valid, outs(), prev_out);
          end
        end
        if (o_valid && i_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got data=%h want no output", outs());
          end else begin
            bundle_t e;
            e = exp_q.pop_front();
            if (outs() !== e) begin
              errors++;
              $display("FAIL bundle got as=%b sw=%b sa=%b sb=%b ea=%h eb=%h ma=%h mb=%h d=%0d want as=%b sw=%b sa=%b sb=%b ea=%h eb=%h ma=%h mb=%h d=%0d",
                       o_add_sub, o_swap, o_sign_a, o_sign_b, o_exp_a, o_exp_b,
                       o_man_a, o_man_b, o_exp_diff, e.add_sub, e.swap, e.sign_a,
                       e.sign_b, e.exp_a, e.exp_b, e.man_a, e.man_b, e.exp_diff);
            end
          end
        end
        prev_stall = o_valid && !i_ready;
        prev_out   = outs();
      end
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      idle(1);
      g++;
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        as;
    #1;
    check_reset_outputs("reset_state");
    #13 i_rst_n = 1'b1;

    // Directed cases
    rdy_mode = 0;
    send(1'b0, 32'h40400000, 32'h3F800000,
         mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h7F, 24'hC00000, 24'h800000, 8'd1));
    send(1'b0, 32'h3F800000, 32'hC1200000,
         mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h82, 8'h7F, 24'hA00000, 24'h800000, 8'd3));
`ifdef FP_UNPACK_DENORM_FLUSH_EN
    send(1'b0, 32'h00000001, 32'h00800000,
         mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 24'h800000, 24'h000000, 8'd0));
`else
    send(1'b0, 32'h00000001, 32'h00800000,
         mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 24'h800000, 24'h000001, 8'd0));
`endif
    send(1'b1, 32'h3F800000, 32'hBF800000,
         mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 8'h7F, 24'h800000, 24'h800000, 8'd0));
    send(1'b1, 32'h7F800000, 32'h00000000,
         mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 24'h800000, 24'h000000, 8'd254));
    drain();

    // Backpressure: four back-to-back pairs, ready low for relative cycles 3..6
    bp_base  = cyc;
    bp_on    = 1'b1;
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom; as = k[0];
      send(as, a, b, model(as, a, b));
    end
    idle(2);
    bp_on    = 1'b0;
    rdy_mode = 0;
    drain();

    // Mid-stream reset with both stages full
    rdy_mode = 3;
    for (int k = 0; k < 2; k++) begin
      a = $urandom; b = $urandom;
      send(1'b0, a, b, model(1'b0, a, b));
    end
    idle(1);
    @(negedge i_clk);
    #3 i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    check_reset_outputs("midstream_reset");
    exp_q.delete();
    @(negedge i_clk);
    #3 i_rst_n = 1'b1;
    rdy_mode = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset got o_valid=%b want 0", o_valid);
      end
    end

    // Randomized traffic with random backpressure and gaps
    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      a  = $urandom;
      b  = $urandom;
      as = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = a ^ 32'h80000000;                        // equal magnitude
        1: b = {b[31], a[30:23], b[22:0]};              // same exponent
        2: a = {a[31], 8'h00, a[22:0]};                 // subnormal A
        3: b = {b[31], 8'h00, b[22:0]};                 // subnormal B
        default: ;
      endcase
      send(as, a, b, model(as, a, b));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rdy_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
